// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and defaults for the multi-word add sequencer and its result FIFO.
package multiword_add_sequencer_pkg;

  localparam int unsigned DEF_WIDTH     = 7;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_MAX_LIMBS = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CHAIN = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 carry;
    logic                 last;
  } res_entry_t;

  // Bits needed to hold values 0..n inclusive.
  function automatic int unsigned count_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_result_fifo.sv
// Synchronous FIFO for per-limb results; head reads zero when empty.
module result_fifo
  import multiword_add_sequencer_pkg::*;
#(
  parameter int unsigned DW    = DEF_WIDTH + 2,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  logic [DW-1:0]                    push_data,
  input  logic                             pop,
  output logic [DW-1:0]                    pop_data,
  output logic                             full,
  output logic                             empty,
  output logic [count_bits(DEPTH)-1:0]     count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = count_bits(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Streams operand limbs through an external adder, chaining carries across a
// sequence and queuing each limb result in a FIFO.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned MAX_LIMBS = DEF_MAX_LIMBS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] limb_a,
  input  logic [WIDTH-1:0] limb_b,
  input  logic             limb_valid,
  output logic             limb_ready,
  input  logic             limb_last,
  input  logic             cin_init,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_c,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CNT_W  = count_bits(MAX_LIMBS);
  localparam int unsigned FCNT_W = count_bits(DEPTH);

  seq_state_t        state;
  logic              carry_q;
  logic [CNT_W-1:0]  limb_cnt;
  logic              err_q;
  logic              accept;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [WIDTH+1:0]  fifo_head;

  assign add_a   = limb_a;
  assign add_b   = limb_b;
  assign add_cin = (state == IDLE) ? cin_init : carry_q;

  assign limb_ready = rst_n && (!fifo_full || res_ready);
  assign accept     = limb_valid && limb_ready;

  result_fifo #(
    .DW    (WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({add_s, add_c, limb_last}),
    .pop       (res_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign res_data  = fifo_head[WIDTH+1:2];
  assign res_carry = fifo_head[1];
  assign res_last  = fifo_head[0];
  assign res_valid = !fifo_empty;
  assign busy      = (state == CHAIN) || (fifo_count != '0);
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      carry_q  <= 1'b0;
      limb_cnt <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      carry_q <= add_c;
      if (state == IDLE) begin
        // The counter restarts at zero and counts this first limb in the same step.
        limb_cnt <= CNT_W'(1);
        state    <= limb_last ? IDLE : CHAIN;
      end else begin
        if (limb_cnt == CNT_W'(MAX_LIMBS)) begin
          err_q <= 1'b1;
        end else begin
          limb_cnt <= limb_cnt + CNT_W'(1);
        end
        if (limb_last) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: behavioural adder, result scoreboard,
// table vectors plus directed back-pressure, reset and overflow sequences.
module tb_multiword_add_sequencer;

  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] limb_a, limb_b;
  logic         limb_valid, limb_ready, limb_last, cin_init;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_cin, add_c;
  logic [W-1:0] res_data;
  logic         res_carry, res_last, res_valid, res_ready;
  logic         busy, err;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         l;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         last;
    logic [W-1:0] d;
    logic         c;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;
  bit   bp = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for carry_look_ahead.
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

  multiword_add_sequencer #(
    .WIDTH     (W),
    .DEPTH     (4),
    .MAX_LIMBS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .limb_a     (limb_a),
    .limb_b     (limb_b),
    .limb_valid (limb_valid),
    .limb_ready (limb_ready),
    .limb_last  (limb_last),
    .cin_init   (cin_init),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_cin    (add_cin),
    .add_s      (add_s),
    .add_c      (add_c),
    .res_data   (res_data),
    .res_carry  (res_carry),
    .res_last   (res_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .err        (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp) res_ready = 1'($urandom_range(0, 1));
  endtask

  // Holds a limb valid until accepted; records the expected result on acceptance.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic last, input logic [W-1:0] ed, input logic ec);
    int unsigned n = 0;
    bit done = 1'b0;
    exp_t e;
    limb_a = a; limb_b = b; cin_init = cin; limb_last = last; limb_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (limb_ready) begin
        e.d = ed; e.c = ec; e.l = last;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        n++;
        if (n > 300) begin
          checks++; errors++;
          $display("FAIL send_timeout limb_ready got 0 expected 1 at %0t", $time);
          done = 1'b1;
        end
      end
      tick();
    end
    limb_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    bp = 1'b0;
    res_ready = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain_queue", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("drain_res_valid", 64'(res_valid), 64'd0);
    tick();
  endtask

  // Reference: limb i of the multi-word sum a + b + cin, with the carry out of that limb.
  function automatic exp_t ref_limb(input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input int unsigned i, input logic last);
    logic [63:0] mask, p;
    exp_t e;
    mask = (64'd1 << (W * (i + 1))) - 64'd1;
    p    = (a & mask) + (b & mask) + {63'd0, cin};
    e.d  = W'(p >> (W * i));
    e.c  = p[W * (i + 1)];
    e.l  = last;
    return e;
  endfunction

  task automatic send_ref(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input int unsigned i, input logic last);
    exp_t e;
    e = ref_limb(a, b, cin, i, last);
    send(W'(a >> (W * i)), W'(b >> (W * i)), cin, last, e.d, e.c);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 7'h7F, b: 7'h01, cin: 1'b0, last: 1'b0, d: 7'h00, c: 1'b1};
    vecs[1] = '{a: 7'h7F, b: 7'h00, cin: 1'b0, last: 1'b1, d: 7'h00, c: 1'b1};
    vecs[2] = '{a: 7'h12, b: 7'h34, cin: 1'b1, last: 1'b1, d: 7'h47, c: 1'b0};
    vecs[3] = '{a: 7'h40, b: 7'h40, cin: 1'b0, last: 1'b1, d: 7'h00, c: 1'b1};
    vecs[4] = '{a: 7'h01, b: 7'h02, cin: 1'b0, last: 1'b0, d: 7'h03, c: 1'b0};
    vecs[5] = '{a: 7'h10, b: 7'h20, cin: 1'b1, last: 1'b1, d: 7'h30, c: 1'b0};
    vecs[6] = '{a: 7'h7F, b: 7'h7F, cin: 1'b1, last: 1'b1, d: 7'h7F, c: 1'b1};

    rst_n = 1'b0; limb_a = '0; limb_b = '0; limb_valid = 1'b0; limb_last = 1'b0;
    cin_init = 1'b0; res_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && res_valid && res_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result got %0h expected none at %0t", res_data, $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", {res_data, res_carry, res_last}, {e.d, e.c, e.l});
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_limb_ready", 64'(limb_ready), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_head", {res_data, res_carry, res_last}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors with the result side always ready.
    res_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].last, vecs[i].d, vecs[i].c);
      if (i == 0) begin
        check("latency_valid", 64'(res_valid), 64'd1);
        check("latency_data", {res_data, res_carry, res_last}, {7'h00, 1'b1, 1'b0});
      end
    end
    drain();
    check("idle_busy", 64'(busy), 64'd0);

    // Fill the FIFO under back-pressure, then push and pop in the same cycle.
    res_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send(W'(10 + i), W'(i), 1'b0, 1'b1, W'(10 + 2 * i), 1'b0);
    limb_a = 7'h60; limb_b = 7'h30; cin_init = 1'b0; limb_last = 1'b1; limb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_limb_ready", 64'(limb_ready), 64'd0);
      check("full_queue", 64'(sb.size()), 64'd4);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("full_pop_ready", 64'(limb_ready), 64'd1);
    if (limb_ready) begin
      exp_t e;
      e.d = 7'h10; e.c = 1'b1; e.l = 1'b1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b0; limb_valid = 1'b0;
    @(negedge clk);
    check("still_full_ready", 64'(limb_ready), 64'd0);
    check("still_full_valid", 64'(res_valid), 64'd1);
    tick();
    drain();

    // Reset in the middle of a chained sequence with two queued entries.
    res_ready = 1'b0;
    send(7'h01, 7'h01, 1'b0, 1'b0, 7'h02, 1'b0);
    send(7'h7F, 7'h02, 1'b0, 1'b0, 7'h01, 1'b1);
    check("chain_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_res_valid", 64'(res_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_limb_ready", 64'(limb_ready), 64'd0);
    limb_a = 7'h05; limb_b = 7'h05; cin_init = 1'b1; limb_last = 1'b1; limb_valid = 1'b1;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_ignored", 64'(res_valid), 64'd0);
    limb_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_cin1", 64'(add_cin), 64'd1);
    cin_init = 1'b0;
    #1;
    check("post_rst_cin0", 64'(add_cin), 64'd0);
    tick();
    send(7'h05, 7'h05, 1'b1, 1'b1, 7'h0B, 1'b0);
    drain();

    // Nine-limb sequence overflows the eight-limb limit.
    begin
      logic [63:0] a, b;
      logic cin;
      a = {1'b0, $urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF;
      b = {1'b0, $urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF;
      cin = 1'($urandom_range(0, 1));
      res_ready = 1'b1;
      for (int unsigned i = 0; i < 9; i++) begin
        send_ref(a, b, cin, i, (i == 8));
        check("err_progress", 64'(err), (i == 8) ? 64'd1 : 64'd0);
      end
      send(7'h01, 7'h01, 1'b0, 1'b1, 7'h02, 1'b0);
      check("err_sticky", 64'(err), 64'd1);
      drain();
    end

    // Random sequences under random result back-pressure.
    bp = 1'b1;
    for (int s = 0; s < 100; s++) begin
      int unsigned len;
      logic [63:0] a, b, mask;
      logic cin;
      len  = $urandom_range(1, 8);
      mask = (64'd1 << (W * len)) - 64'd1;
      a    = {$urandom, $urandom} & mask;
      b    = {$urandom, $urandom} & mask;
      cin  = 1'($urandom_range(0, 1));
      for (int unsigned i = 0; i < len; i++) begin
        send_ref(a, b, cin, i, (i == len - 1));
        repeat ($urandom_range(0, 1)) tick();
      end
    end
    drain();
    check("final_err", 64'(err), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
